wb_regbus_bridge: RTL and testbench

//   Initiator side of the peripheral register bus: converts one classic Wishbone

---
 rtl/wb_regbus_bridge_pkg.sv | 16 +
 rtl/wb_regbus_bridge_if.sv | 42 ++++
 rtl/wb_regbus_bridge.sv | 112 +++++++++++
 tb/tb_wb_regbus_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_regbus_bridge_pkg.sv
// Shared types and default constants for the Wishbone-to-register-bus bridge.
package wb_regbus_bridge_pkg;

    // Bridge sequencing: wait for a strobe, hold the request, then one completion cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } br_state_e;

    localparam int          AW_DEFAULT          = 11;
    localparam int          DW_DEFAULT          = 32;
    localparam int          TIMEOUT_CYC_DEFAULT = 256;
    localparam logic [31:0] ERR_RDATA_DEFAULT   = 32'hDEAD_0BAD;

endpackage : wb_regbus_bridge_pkg

// File: rtl/wb_regbus_bridge_if.sv
// Signal bundle for the bridge: Wishbone slave side plus peripheral register side.
interface wb_regbus_bridge_if #(
    parameter int AW = 11,
    parameter int DW = 32
) ();
    // Wishbone side
    logic            wbs_cyc_i;
    logic            wbs_stb_i;
    logic            wbs_we_i;
    logic [AW-1:0]   wbs_adr_i;
    logic [DW-1:0]   wbs_dat_i;
    logic [DW/8-1:0] wbs_sel_i;
    logic [DW-1:0]   wbs_dat_o;
    logic            wbs_ack_o;
    logic            wbs_err_o;

    // Peripheral register side
    logic            reg_cs;
    logic            reg_wr;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_be;
    logic [DW-1:0]   reg_rdata;
    logic            reg_ack;

    // Wishbone master plus peripheral responder (environment view).
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );

    // Bridge view.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

endinterface : wb_regbus_bridge_if

// File: rtl/wb_regbus_bridge.sv
// Converts one classic Wishbone access into a held reg_cs/reg_ack transaction,
// with a timeout that answers wbs_err_o when the responder never acks.
module wb_regbus_bridge
    import wb_regbus_bridge_pkg::*;
#(
    parameter int          AW          = AW_DEFAULT,
    parameter int          DW          = DW_DEFAULT,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
    input  logic                mclk,
    input  logic                s_reset_n,
    wb_regbus_bridge_if.slave   bus,
    output logic                timeout_sts
);

    localparam int            CW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam int            BW        = DW / 8;

    br_state_e       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            cs_reg;
    logic            wr_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [BW-1:0]   be_reg;
    logic [DW-1:0]   rdata_reg;
    logic            ack_reg;
    logic            err_reg;
    logic            sts_reg;

    // Request/response sequencing; every output comes straight from a register.
    always_ff @(posedge mclk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cs_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            sts_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    err_reg <= 1'b0;
                    cnt_reg <= '0;
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        wr_reg    <= bus.wbs_we_i;
                        addr_reg  <= bus.wbs_adr_i;
                        wdata_reg <= bus.wbs_dat_i;
                        be_reg    <= bus.wbs_sel_i;
                        cs_reg    <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // Abort beats ack, and ack beats the timeout.
                    if (!bus.wbs_cyc_i) begin
                        cs_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (bus.reg_ack) begin
                        cs_reg    <= 1'b0;
                        rdata_reg <= wr_reg ? '0 : bus.reg_rdata;
                        ack_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        cs_reg    <= 1'b0;
                        rdata_reg <= DW'(ERR_RDATA);
                        err_reg   <= 1'b1;
                        sts_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Completion pulse lasts this one cycle; the dead cycle also
                    // keeps a still-high strobe from re-triggering immediately.
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    cs_reg    <= 1'b0;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.reg_cs    = cs_reg;
    assign bus.reg_wr    = wr_reg;
    assign bus.reg_addr  = addr_reg;
    assign bus.reg_wdata = wdata_reg;
    assign bus.reg_be    = be_reg;
    assign bus.wbs_dat_o = rdata_reg;
    assign bus.wbs_ack_o = ack_reg;
    assign bus.wbs_err_o = err_reg;
    assign timeout_sts   = sts_reg;

endmodule : wb_regbus_bridge

// File: tb/tb_wb_regbus_bridge.sv
// Directed bench for wb_regbus_bridge with hand-computed expectations.
module tb_wb_regbus_bridge;

    localparam int TO = 16;

    logic mclk = 1'b0;
    logic s_reset_n;
    logic timeout_sts;

    int n_vectors     = 0;
    int n_miscompares = 0;

    wb_regbus_bridge_if #(.AW(11), .DW(32)) bus ();

    wb_regbus_bridge #(
        .AW          (11),
        .DW          (32),
        .TIMEOUT_CYC (TO),
        .ERR_RDATA   (32'hDEAD_0BAD)
    ) dut (
        .mclk        (mclk),
        .s_reset_n   (s_reset_n),
        .bus         (bus),
        .timeout_sts (timeout_sts)
    );

    always #5 mclk = ~mclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One Wishbone access. ack_at / abort_at are 1-based reg_cs cycle numbers (0 = never).
    // lat is the cycle (stb cycle = 1) in which ack or err is first seen.
    task automatic run_access(input logic we, input logic [10:0] adr, input logic [31:0] wdat,
                              input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                              input int abort_at, output int lat, output int cs_cnt,
                              output int acks, output int errs, output logic [31:0] dout,
                              output int hold_bad);
        int  cycle;
        bit  done;
        bit  stop;
        lat = 0; cs_cnt = 0; acks = 0; errs = 0; dout = '0; hold_bad = 0;
        done = 1'b0; stop = 1'b0;
        @(posedge mclk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        cycle = 1;
        while (!stop && cycle < TO + 40) begin
            bus.reg_ack = 1'b0;
            if (done) stop = 1'b1;
            if (bus.reg_cs) begin
                cs_cnt++;
                if (bus.reg_wr !== we || bus.reg_addr !== adr ||
                    bus.reg_wdata !== wdat || bus.reg_be !== sel)
                    hold_bad++;
                if (cs_cnt == ack_at) begin
                    bus.reg_ack   = 1'b1;
                    bus.reg_rdata = rdat;
                end
                if (cs_cnt == abort_at && !done) begin
                    bus.wbs_cyc_i = 1'b0;
                    bus.wbs_stb_i = 1'b0;
                    done = 1'b1;
                end
            end
            if (bus.wbs_ack_o) begin
                acks++;
                if (lat == 0) begin lat = cycle; dout = bus.wbs_dat_o; end
            end
            if (bus.wbs_err_o) begin
                errs++;
                if (lat == 0) begin lat = cycle; dout = bus.wbs_dat_o; end
            end
            if ((bus.wbs_ack_o || bus.wbs_err_o) && !done) begin
                done = 1'b1;
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
            end
            if (!stop) begin
                @(posedge mclk); #1;
                cycle++;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.reg_ack   = 1'b0;
        $display("access we=%0d adr=0x%03h: lat=%0d cs_cycles=%0d acks=%0d errs=%0d dat=0x%08h sts=%0d",
                 we, adr, lat, cs_cnt, acks, errs, dout, timeout_sts);
    endtask

    int          lat, cs_cnt, acks, errs, hold_bad, stray;
    logic [31:0] dout;

    initial begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_sel_i = '0;
        bus.reg_rdata = '0;   bus.reg_ack   = 1'b0;
        s_reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check_val("rst_cs",  32'(bus.reg_cs),    32'd0);
        check_val("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check_val("rst_err", 32'(bus.wbs_err_o), 32'd0);
        check_val("rst_dat", bus.wbs_dat_o,      32'd0);
        check_val("rst_sts", 32'(timeout_sts),   32'd0);
        @(negedge mclk);
        s_reset_n = 1'b1;

        // 1: write, ack on 2nd cs cycle
        run_access(1'b1, 11'h084, 32'h1234_5678, 4'hF, 2, 32'hFFFF_FFFF, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t1_lat",  32'(lat),      32'd4);
        check_val("t1_cs",   32'(cs_cnt),   32'd2);
        check_val("t1_acks", 32'(acks),     32'd1);
        check_val("t1_errs", 32'(errs),     32'd0);
        check_val("t1_hold", 32'(hold_bad), 32'd0);
        check_val("t1_dat",  dout,          32'd0);

        // 2: read, ack on 1st cs cycle
        run_access(1'b0, 11'h100, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t2_lat",  32'(lat),      32'd3);
        check_val("t2_acks", 32'(acks),     32'd1);
        check_val("t2_hold", 32'(hold_bad), 32'd0);
        check_val("t2_dat",  dout,          32'hCAFE_F00D);

        // 4: write acked on the last timeout cycle -> ack only, data 0 for writes
        run_access(1'b1, 11'h0FC, 32'hA5A5_5A5A, 4'h3, TO, 32'h1111_2222, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t4_lat",  32'(lat),         32'd18);
        check_val("t4_cs",   32'(cs_cnt),      32'd16);
        check_val("t4_acks", 32'(acks),        32'd1);
        check_val("t4_errs", 32'(errs),        32'd0);
        check_val("t4_dat",  dout,             32'd0);
        check_val("t4_sts",  32'(timeout_sts), 32'd0);

        // 5: abort on 3rd REQ cycle, then a stray reg_ack
        run_access(1'b0, 11'h010, 32'h0, 4'hF, 0, 32'h0, 3,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t5_cs",   32'(cs_cnt), 32'd3);
        check_val("t5_acks", 32'(acks),   32'd0);
        check_val("t5_errs", 32'(errs),   32'd0);
        stray = 0;
        @(posedge mclk); #1;
        bus.reg_ack = 1'b1; bus.reg_rdata = 32'h7777_7777;
        @(posedge mclk); #1;
        bus.reg_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.wbs_ack_o || bus.wbs_err_o || bus.reg_cs) stray++;
            @(posedge mclk); #1;
        end
        check_val("t5_stray", 32'(stray), 32'd0);
        run_access(1'b0, 11'h020, 32'h0, 4'h1, 2, 32'h0BAD_CAFE, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t5_next_lat", 32'(lat), 32'd4);
        check_val("t5_next_dat", dout,     32'h0BAD_CAFE);

        // 3: no responder -> timeout
        run_access(1'b0, 11'h1FC, 32'h0, 4'hF, 0, 32'h0, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t3_lat",  32'(lat),         32'd18);
        check_val("t3_cs",   32'(cs_cnt),      32'd16);
        check_val("t3_acks", 32'(acks),        32'd0);
        check_val("t3_errs", 32'(errs),        32'd1);
        check_val("t3_dat",  dout,             32'hDEAD_0BAD);
        check_val("t3_sts",  32'(timeout_sts), 32'd1);
        run_access(1'b1, 11'h008, 32'h0000_00FF, 4'h1, 1, 32'h0, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t3_after_acks", 32'(acks),        32'd1);
        check_val("t3_after_sts",  32'(timeout_sts), 32'd1);

        // 6: async reset mid-REQ
        @(posedge mclk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = 11'h0AA; bus.wbs_dat_i = 32'h5555_AAAA; bus.wbs_sel_i = 4'hF;
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        check_val("t6_cs_pre", 32'(bus.reg_cs), 32'd1);
        #2 s_reset_n = 1'b0;
        #1;
        check_val("t6_cs",   32'(bus.reg_cs),    32'd0);
        check_val("t6_wr",   32'(bus.reg_wr),    32'd0);
        check_val("t6_addr", 32'(bus.reg_addr),  32'd0);
        check_val("t6_ack",  32'(bus.wbs_ack_o), 32'd0);
        check_val("t6_err",  32'(bus.wbs_err_o), 32'd0);
        check_val("t6_sts",  32'(timeout_sts),   32'd0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(negedge mclk);
        s_reset_n = 1'b1;
        run_access(1'b0, 11'h044, 32'h0, 4'hF, 1, 32'h600D_D00D, 0,
                   lat, cs_cnt, acks, errs, dout, hold_bad);
        check_val("t6_next_lat", 32'(lat),  32'd3);
        check_val("t6_next_ack", 32'(acks), 32'd1);
        check_val("t6_next_dat", dout,      32'h600D_D00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_wb_regbus_bridge
